// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm stage: FSM states, set-position codes,
// time-of-day fields and the wrap-around increment used by the alarm setter.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [1:0] POS_MIN = 2'd0;
  localparam logic [1:0] POS_HR  = 2'd1;

  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_HR  = 6'd23;

  typedef struct packed {
    logic [5:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Restartable prescaler: one-cycle o_tick every CLK_HZ cycles, count held at 0 on i_restart.
// No backpressure; the first tick after a restart comes CLK_HZ cycles later.
module sec_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == LAST);

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: double-samples the live time, rings on a rising match, supports stop/snooze/timeout.
// Ring begins 3 clk after the matching time settles; all outputs registered, no backpressure.
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TONE_DIV   = 25000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_hr,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_alarm_en,
  input  logic [1:0] i_set_pos,
  input  logic       i_set_inc,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic [5:0] o_alarm_hr,
  output logic [5:0] o_alarm_min,
  output logic       o_ringing,
  output logic       o_snoozing,
  output logic       o_buzz
);

  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TW-1:0] TONE_LAST   = TW'(TONE_DIV - 1);
  localparam logic [8:0]    RING_LAST   = 9'(RING_SEC - 1);
  localparam logic [8:0]    SNOOZE_LAST = 9'(SNOOZE_SEC - 1);

  time_t         s1, s2;
  logic          valid, match_now, match_q, evt;
  state_t        state, state_n;
  logic          restart, tick;
  logic [8:0]    sec_cnt;
  logic [TW-1:0] tone_cnt;

  // Two-stage capture; equal consecutive samples mean no bit skew in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      match_q <= 1'b0;
    end else begin
      s1      <= {i_hr, i_min, i_sec};
      s2      <= s1;
      match_q <= match_now;
    end
  end

  assign valid     = (s1 == s2);
  assign match_now = valid && i_alarm_en && (s2.hr == o_alarm_hr) &&
                     (s2.min == o_alarm_min) && (s2.sec == 6'd0);
  assign evt       = match_now && !match_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_alarm_hr  <= 6'd0;
      o_alarm_min <= 6'd0;
    end else if (i_set_inc) begin
      if (i_set_pos == POS_MIN) begin
        o_alarm_min <= wrap_inc(o_alarm_min, MAX_MIN);
      end else if (i_set_pos == POS_HR) begin
        o_alarm_hr <= wrap_inc(o_alarm_hr, MAX_HR);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (evt) state_n = RING;
      end
      RING: begin
        if (i_stop || !i_alarm_en)             state_n = IDLE;
        else if (i_snooze)                     state_n = SNOOZE;
        else if (tick && sec_cnt == RING_LAST) state_n = IDLE;
      end
      SNOOZE: begin
        if (i_stop || !i_alarm_en)               state_n = IDLE;
        else if (tick && sec_cnt == SNOOZE_LAST) state_n = RING;
      end
      default: state_n = IDLE;
    endcase
  end

  // Every state entry restarts the second base so durations are whole seconds.
  assign restart = (state_n != state);

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (restart),
    .o_tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sec_cnt    <= 9'd0;
      tone_cnt   <= '0;
      o_buzz     <= 1'b0;
      o_ringing  <= 1'b0;
      o_snoozing <= 1'b0;
    end else begin
      state      <= state_n;
      o_ringing  <= (state_n == RING);
      o_snoozing <= (state_n == SNOOZE);
      if (restart) begin
        sec_cnt <= 9'd0;
      end else if (tick) begin
        sec_cnt <= sec_cnt + 9'd1;
      end
      // Tone runs only while staying in RING; entry and exit both silence it.
      if (state == RING && state_n == RING) begin
        if (tone_cnt == TONE_LAST) begin
          tone_cnt <= '0;
          o_buzz   <= ~o_buzz;
        end else begin
          tone_cnt <= tone_cnt + 1'b1;
        end
      end else begin
        tone_cnt <= '0;
        o_buzz   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed plus randomized checks of alarm_unit against timing and setting rules
// computed in the bench (CLK_HZ=10, TONE_DIV=2, RING_SEC=3, SNOOZE_SEC=2).
module tb_alarm_unit;

  localparam int CLK_HZ     = 10;
  localparam int TONE_DIV   = 2;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;
  localparam int RING_CYC   = RING_SEC * CLK_HZ;
  localparam int SNOOZE_CYC = SNOOZE_SEC * CLK_HZ;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] i_hr, i_min, i_sec;
  logic       i_alarm_en;
  logic [1:0] i_set_pos;
  logic       i_set_inc, i_stop, i_snooze;
  logic [5:0] o_alarm_hr, o_alarm_min;
  logic       o_ringing, o_snoozing, o_buzz;

  int errors = 0;
  int checks = 0;
  int mhr = 0;
  int mmin = 0;

  alarm_unit #(
    .CLK_HZ(CLK_HZ), .TONE_DIV(TONE_DIV), .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)
  ) dut (
    .clk(clk), .rst(rst), .i_hr(i_hr), .i_min(i_min), .i_sec(i_sec),
    .i_alarm_en(i_alarm_en), .i_set_pos(i_set_pos), .i_set_inc(i_set_inc),
    .i_stop(i_stop), .i_snooze(i_snooze), .o_alarm_hr(o_alarm_hr),
    .o_alarm_min(o_alarm_min), .o_ringing(o_ringing), .o_snoozing(o_snoozing),
    .o_buzz(o_buzz)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    i_hr  = 6'(h);
    i_min = 6'(m);
    i_sec = 6'(s);
  endtask

  task automatic press(input int pos);
    i_set_pos = 2'(pos);
    i_set_inc = 1'b1;
    step(1);
    i_set_inc = 1'b0;
    if (pos == 0) mmin = (mmin + 1) % 60;
    if (pos == 1) mhr  = (mhr + 1) % 24;
  endtask

  // Leaves the bench one sample after the ring has begun.
  task automatic start_ring(input int h, input int m);
    set_time(h, m, 1);
    step(3);
    set_time(h, m, 0);
    step(2);
    chk("ring_latency_pre", o_ringing, 0);
    step(1);
    chk("ring_latency", o_ringing, 1);
  endtask

  initial begin
    rst = 1'b1; i_alarm_en = 1'b0; i_set_pos = 2'd3; i_set_inc = 1'b0;
    i_stop = 1'b0; i_snooze = 1'b0;
    set_time(1, 2, 3);
    step(2);
    rst = 1'b0;
    chk("reset_hr", o_alarm_hr, 0);
    chk("reset_min", o_alarm_min, 0);
    chk("reset_ringing", o_ringing, 0);
    chk("reset_snoozing", o_snoozing, 0);
    chk("reset_buzz", o_buzz, 0);

    // Alarm setting with wrap.
    repeat (7) press(1);
    repeat (30) press(0);
    chk("set_hr", o_alarm_hr, 7);
    chk("set_min", o_alarm_min, 30);
    repeat (30) press(0);
    chk("min_wrap", o_alarm_min, 0);
    repeat (24) press(1);
    chk("hr_wrap", o_alarm_hr, 7);

    // Random walk over set positions, including ignored ones.
    for (int i = 0; i < 40; i++) begin
      press(int'($urandom_range(0, 3)));
      chk("rand_set_hr", o_alarm_hr, 32'(mhr));
      chk("rand_set_min", o_alarm_min, 32'(mmin));
    end
    while (mhr != 7) press(1);
    while (mmin != 30) press(0);
    chk("restore_hr", o_alarm_hr, 7);
    chk("restore_min", o_alarm_min, 30);

    // Ring, tone and timeout.
    i_alarm_en = 1'b1;
    set_time(7, 29, 59);
    step(3);
    set_time(7, 30, 0);
    step(2);
    chk("s2_not_yet", o_ringing, 0);
    step(1);
    for (int k = 0; k < RING_CYC; k++) begin
      chk("ring_hold", o_ringing, 1);
      chk("buzz_wave", o_buzz, 32'((k / TONE_DIV) % 2));
      step(1);
    end
    chk("timeout_ring", o_ringing, 0);
    chk("timeout_buzz", o_buzz, 0);
    step(10);
    chk("no_rering_same_min", o_ringing, 0);

    // Snooze then resume then stop.
    start_ring(7, 30);
    i_snooze = 1'b1;
    step(1);
    i_snooze = 1'b0;
    chk("snooze_flag", o_snoozing, 1);
    chk("snooze_ring", o_ringing, 0);
    chk("snooze_buzz", o_buzz, 0);
    for (int j = 1; j < SNOOZE_CYC; j++) begin
      step(1);
      chk("snooze_hold", o_snoozing, 1);
    end
    chk("snooze_not_yet", o_ringing, 0);
    step(1);
    chk("resume_ring", o_ringing, 1);
    chk("resume_snooze", o_snoozing, 0);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    chk("stop_ring", o_ringing, 0);
    chk("stop_snooze", o_snoozing, 0);

    // Stop and snooze together.
    start_ring(7, 30);
    step(2);
    i_stop = 1'b1; i_snooze = 1'b1;
    step(1);
    i_stop = 1'b0; i_snooze = 1'b0;
    chk("both_ring", o_ringing, 0);
    chk("both_snooze", o_snoozing, 0);
    for (int j = 0; j < 5; j++) begin
      step(1);
      chk("both_no_snooze", o_snoozing, 0);
    end

    // Unstable time never rings.
    for (int i = 0; i < 20; i++) begin
      set_time(7, (i % 2 != 0) ? 31 : 30, 0);
      step(1);
      chk("skew_no_ring", o_ringing, 0);
    end
    step(4);
    chk("skew_settled", o_ringing, 0);

    // Disabled alarm never rings.
    set_time(7, 29, 59);
    step(3);
    i_alarm_en = 1'b0;
    set_time(7, 30, 0);
    for (int j = 0; j < 6; j++) begin
      step(1);
      chk("en0_no_ring", o_ringing, 0);
    end
    set_time(7, 29, 59);
    step(3);
    i_alarm_en = 1'b1;

    // Dropping enable mid-ring.
    start_ring(7, 30);
    step(1);
    i_alarm_en = 1'b0;
    step(1);
    chk("en_drop_ring", o_ringing, 0);
    chk("en_drop_buzz", o_buzz, 0);
    set_time(7, 29, 59);
    step(3);
    i_alarm_en = 1'b1;

    // Reset while buzzing.
    start_ring(7, 30);
    step(2);
    chk("pre_rst_buzz", o_buzz, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    mhr = 0; mmin = 0;
    chk("rst_buzz", o_buzz, 0);
    chk("rst_ring", o_ringing, 0);
    chk("rst_snooze", o_snoozing, 0);
    chk("rst_hr", o_alarm_hr, 0);
    chk("rst_min", o_alarm_min, 0);

    // Random alarm and random non-matching times.
    i_alarm_en = 1'b0;
    repeat (30) press(int'($urandom_range(0, 1)));
    chk("rand2_hr", o_alarm_hr, 32'(mhr));
    chk("rand2_min", o_alarm_min, 32'(mmin));
    set_time(mhr, mmin, 1);
    step(3);
    i_alarm_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      int h, m, s;
      h = int'($urandom_range(0, 23));
      m = int'($urandom_range(0, 59));
      s = int'($urandom_range(0, 59));
      if ($urandom_range(0, 3) == 0) begin h = mhr; m = mmin; end
      if (h == mhr && m == mmin && s == 0) s = 1;
      set_time(h, m, s);
      step(int'($urandom_range(1, 4)));
      chk("rand_no_ring", o_ringing, 0);
    end
    start_ring(mhr, mmin);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    chk("rand_stop", o_ringing, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
- Alarm stage downstream of the hour/minute/second counter block. Consumes its 6-bit hr/min/sec values and holds a user-settable alarm time (hour, minute).
- Raises a ringing state with a square-wave buzzer output when the live time reaches the alarm time. Supports stop, snooze and automatic timeout.
- Outputs drive the buzzer pin and status LEDs. o_alarm_hr/o_alarm_min can be multiplexed into the 6-digit display path.

Parameters:
- CLK_HZ, 50000000, clk cycles per internal 1 s tick.
- TONE_DIV, 25000, clk cycles per o_buzz half-period (1 kHz tone at 50 MHz).
- RING_SEC, 60, seconds of ringing before automatic return to idle.
- SNOOZE_SEC, 300, seconds spent in snooze before ringing resumes.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- i_hr  in  6  live hour 0..23 from counter block (asynchronous to clk).
- i_min  in  6  live minute 0..59 (asynchronous to clk).
- i_sec  in  6  live second 0..59 (asynchronous to clk).
- i_alarm_en  in  1  level; alarm armed when 1.
- i_set_pos  in  2  0 = minute, 1 = hour, 2/3 = no target.
- i_set_inc  in  1  single-cycle pulse; increment the selected alarm field.
- i_stop  in  1  single-cycle pulse; cancel ring/snooze.
- i_snooze  in  1  single-cycle pulse; snooze while ringing.
- o_alarm_hr  out  6  stored alarm hour.
- o_alarm_min  out  6  stored alarm minute.
- o_ringing  out  1  high in RING.
- o_snoozing  out  1  high in SNOOZE.
- o_buzz  out  1  tone output; 0 outside RING.

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous and active-high on rst. All state changes happen on posedge clk.
- Reset values:
  - o_alarm_hr = 0, o_alarm_min = 0.
  - state = IDLE, so o_ringing = 0 and o_snoozing = 0.
  - o_buzz = 0.
  - All counters and sync registers = 0.
- Input capture: the 18-bit {i_hr, i_min, i_sec} is registered into s1, then s1 into s2, every clk. A sample is valid only when s1 == s2, which rejects multi-bit skew.
- Match detection:
  - match_now = valid & i_alarm_en & (s2.hr == o_alarm_hr) & (s2.min == o_alarm_min) & (s2.sec == 0).
  - match_q is match_now registered.
  - event = match_now & ~match_q. An event fires once per minute of match.
- Latency: time inputs settle at the matching value before edge 1; o_ringing is high after edge 3.
- Alarm setting:
  - i_set_inc with pos 0: minute +1, wrapping 59 -> 0.
  - i_set_inc with pos 1: hour +1, wrapping 23 -> 0.
  - pos 2/3: ignored.
  - Accepted in any state; the update is visible the next cycle.
  - A change of the alarm time during RING/SNOOZE does not affect the current ring.
- Second tick: a restartable prescaler counts 0..CLK_HZ-1 and pulses at CLK_HZ-1. It restarts from 0 on every state entry, so each RING/SNOOZE duration is exactly N*CLK_HZ cycles.
- State IDLE:
  - Transition: event -> RING.
  - On entering RING, ring_sec = 0, tone_cnt = 0, o_buzz = 0.
- State RING (priority top-down):
  - rst -> IDLE.
  - i_stop or ~i_alarm_en -> IDLE.
  - i_snooze -> SNOOZE.
  - ring_sec reaching RING_SEC -> IDLE.
  - Otherwise stay in RING.
  - o_buzz toggles when tone_cnt == TONE_DIV-1, then tone_cnt = 0; the first toggle is TONE_DIV cycles after entry.
  - Simultaneous i_stop and i_snooze -> IDLE.
- State SNOOZE:
  - i_stop or ~i_alarm_en -> IDLE.
  - snooze_sec reaching SNOOZE_SEC -> RING; ring_sec restarts at 0.
  - o_buzz = 0.
  - i_snooze is ignored.
- Events in RING/SNOOZE: ignored, no restart.
- Outputs: o_buzz is forced to 0 in the same cycle the state leaves RING. All outputs are registered.
- Reset mid-ring: the next cycle is IDLE with the buzzer silent and the alarm time cleared to 0:00.
- Widths:
  - Prescaler: $clog2(CLK_HZ).
  - Tone counter: $clog2(TONE_DIV).
  - Second counters: 9 bits. RING_SEC and SNOOZE_SEC must each be <= 511.

Decomposition:
- Package alarm_pkg:
  - State enum IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2.
  - Set-position constants POS_MIN = 2'd0, POS_HR = 2'd1.
  - Limits MAX_MIN = 59, MAX_HR = 23.
- Sub-module sec_tick_gen: parameter CLK_HZ; ports clk, rst, i_restart, o_tick. It is the restartable prescaler and is also reusable by a future stopwatch block.
- FSM, sync/match logic and the tone divider stay in alarm_unit.

Test Plan:
All scenarios use bench parameters CLK_HZ = 10, TONE_DIV = 2, RING_SEC = 3, SNOOZE_SEC = 2.
1. Reset, then 7 i_set_inc pulses with pos 1 and 30 with pos 0 -> o_alarm_hr = 7, o_alarm_min = 30. Then 30 more pos-0 pulses -> o_alarm_min = 0 (wrap).
2. Alarm 07:30, en = 1; drive time 07:29:59 then 07:30:00 -> o_ringing high 3 cycles after the change. o_buzz toggles every 2 cycles. After 30 cycles o_ringing = 0 (timeout) and holds 0 while 07:30:00 persists.
3. Ringing; pulse i_snooze -> o_snoozing = 1 and o_buzz = 0 next cycle. Exactly 20 cycles later o_ringing = 1 again. Then pulse i_stop -> IDLE, both flags 0.
4. Ringing; i_stop and i_snooze pulsed in the same cycle -> IDLE next cycle, o_snoozing never 1.
5. Time toggling between 07:30:00 and 07:31:00 every cycle (unstable, s1 != s2) -> no ring. Alarm matching with en = 0 -> no ring. Dropping en mid-ring -> IDLE next cycle.
6. Assert rst during RING with buzz = 1 -> next cycle o_buzz = 0, o_ringing = 0, alarm = 00:00.
